// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: key code constants, the scan
// FSM state encoding and the (row, col) -> key code map.
package keypad_pkg;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;  // start
    localparam logic [3:0] KEY_B = 4'hB;  // zero
    localparam logic [3:0] KEY_C = 4'hC;  // confirm
    localparam logic [3:0] KEY_D = 4'hD;  // void
    localparam logic [3:0] KEY_E = 4'hE;  // '*'
    localparam logic [3:0] KEY_F = 4'hF;  // '#'

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_0;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_E;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_F;
            4'b11_11: code = KEY_D;
            default:  code = KEY_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_encoder_sync.sv
// Two-flop synchroniser for the active-low keypad rows.
// Ports:
//   clk_i    system clock
//   rst_n_i  async active-low reset; outputs reset to all-ones (no key)
//   d_i      asynchronous row inputs
//   q_o      synchronised rows
module keypad_sync (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner with debounce and key encoding.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   SCAN     | walk columns, sample rows on the last clock of each slot
//   DEBOUNCE | column frozen, count stable-low samples of the latched row
//   PRESSED  | key accepted, outputs held, other keys ignored
//   RELEASE  | count stable-high samples; a low sample returns to PRESSED
//
// Ports:
//   clk_i          system clock
//   rst_n_i        async active-low reset
//   row_n_i        keypad rows, active-low, asynchronous
//   col_n_o        column drive, one-hot active-low
//   key_code_o     encoded key, 0 when no key accepted
//   key_pressed_o  high while the accepted key is held
//   key_valid_o    one-clock strobe on each new accepted press
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] row_n_i,
    output logic [3:0] col_n_o,
    output logic [3:0] key_code_o,
    output logic       key_pressed_o,
    output logic       key_valid_o
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_CYC);

    logic [3:0]        row_s;
    state_e            state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        code_q, code_d;
    logic              pressed_q, pressed_d;
    logic              valid_q, valid_d;
    logic [1:0]        low_row;
    logic              row_sel;

    keypad_sync u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (row_n_i),
        .q_o     (row_s)
    );

    // Lowest-index active row wins when several keys share a column.
    always_comb begin
        low_row = 2'd3;
        if (!row_s[2]) low_row = 2'd2;
        if (!row_s[1]) low_row = 2'd1;
        if (!row_s[0]) low_row = 2'd0;
    end

    assign row_sel = row_s[row_q];

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        pressed_d = pressed_q;
        valid_d   = 1'b0;
        case (state_q)
            SCAN: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    if (row_s != 4'hF) begin
                        row_d   = low_row;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_sel) begin
                    // Bounce before acceptance: resume scanning at the next column.
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    slot_d  = '0;
                end else if (cnt_q == CNT_DONE) begin
                    code_d    = key_map(row_q, col_q);
                    pressed_d = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (row_sel) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!row_sel) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_DONE) begin
                    code_d    = KEY_0;
                    pressed_d = 1'b0;
                    state_d   = SCAN;
                    col_d     = col_q + 2'd1;
                    slot_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            slot_q    <= '0;
            cnt_q     <= '0;
            code_q    <= KEY_0;
            pressed_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            pressed_q <= pressed_d;
            valid_q   <= valid_d;
        end
    end

    assign col_n_o       = ~(4'b0001 << col_q);
    assign key_code_o    = code_q;
    assign key_pressed_o = pressed_q;
    assign key_valid_o   = valid_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
module tb_keypad_scan_encoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_pressed;
    logic       key_valid;

    logic [3:0][3:0] keys;  // keys[row][col] = 1 when physically held

    int n_checks;
    int n_errors;
    int valid_cnt;
    bit prev_valid;
    bit wide_err;
    bit watch_pressed;
    bit pressed_drop;

    keypad_scan_encoder #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .row_n_i       (row_n),
        .col_n_o       (col_n),
        .key_code_o    (key_code),
        .key_pressed_o (key_pressed),
        .key_valid_o   (key_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Passive matrix: a held key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) valid_cnt++;
        if (key_valid && prev_valid) wide_err = 1'b1;
        prev_valid = key_valid;
        if (watch_pressed && !key_pressed) pressed_drop = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_released(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (!key_pressed) seen = 1'b1;
        end
        check({tag, "_released"}, 32'(seen), 32'd1);
        check({tag, "_code_clr"}, 32'(key_code), 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] pat, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (col_n == pat) seen = 1'b1;
        end
        check("wait_col", 32'(seen), 32'd1);
    endtask

    // Press one key, verify code/level/strobe count, release and verify clear.
    task automatic press_key(input string tag, input int r, input int c, input logic [3:0] exp_code);
        int v0;
        v0 = valid_cnt;
        keys[r][c] = 1'b1;
        wait_valid(tag, 100);
        check({tag, "_code"}, 32'(key_code), 32'(exp_code));
        check({tag, "_pressed"}, 32'(key_pressed), 32'd1);
        repeat (20) @(negedge clk);
        check({tag, "_one_valid"}, 32'(valid_cnt - v0), 32'd1);
        keys[r][c] = 1'b0;
        wait_released(tag, 100);
    endtask

    initial begin
        int v0;
        bit moved;
        n_checks = 0; n_errors = 0; valid_cnt = 0;
        prev_valid = 0; wide_err = 0; watch_pressed = 0; pressed_drop = 0;
        keys = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col_n), 32'hE);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_pressed", 32'(key_pressed), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        rst_n = 1'b1;

        // Idle scan: column advances every 4 clocks.
        repeat (4) @(negedge clk);
        check("scan_col1", 32'(col_n), 32'hD);
        repeat (4) @(negedge clk);
        check("scan_col2", 32'(col_n), 32'hB);
        repeat (8) @(negedge clk);

        // Key '1' held for 100 clocks.
        v0 = valid_cnt;
        keys[0][0] = 1'b1;
        repeat (100) @(negedge clk);
        check("k1_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("k1_code", 32'(key_code), 32'h1);
        check("k1_pressed", 32'(key_pressed), 32'd1);
        keys[0][0] = 1'b0;
        repeat (2 + 8 + 2) @(negedge clk);
        check("k1_rel_code", 32'(key_code), 32'h0);
        check("k1_rel_pressed", 32'(key_pressed), 32'd0);
        repeat (4) @(negedge clk);

        press_key("start", 0, 3, 4'hA);
        press_key("confirm", 2, 3, 4'hC);
        press_key("zero", 1, 3, 4'hB);
        press_key("void", 3, 3, 4'hD);

        // Short press on r0/c2: low for 5 clocks only, must be rejected.
        v0 = valid_cnt;
        wait_col(4'hD, 40);
        wait_col(4'hB, 10);
        keys[0][2] = 1'b1;
        repeat (5) @(negedge clk);
        check("bounce_frozen", 32'(col_n), 32'hB);
        keys[0][2] = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 20 && !moved; i++) begin
            @(negedge clk);
            if (col_n != 4'hB) moved = 1'b1;
        end
        check("bounce_resume", 32'(moved), 32'd1);
        repeat (40) @(negedge clk);
        check("bounce_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("bounce_pressed", 32'(key_pressed), 32'd0);

        // Key '0' (r3/c1) with two 3-clock release glitches.
        v0 = valid_cnt;
        keys[3][1] = 1'b1;
        wait_valid("k0", 100);
        check("k0_code", 32'(key_code), 32'h0);
        check("k0_pressed", 32'(key_pressed), 32'd1);
        pressed_drop = 1'b0;
        watch_pressed = 1'b1;
        for (int g = 0; g < 2; g++) begin
            keys[3][1] = 1'b0;
            repeat (3) @(negedge clk);
            keys[3][1] = 1'b1;
            repeat (6) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        watch_pressed = 1'b0;
        check("k0_no_drop", 32'(pressed_drop), 32'd0);
        check("k0_one_valid", 32'(valid_cnt - v0), 32'd1);
        check("k0_code_hold", 32'(key_code), 32'h0);
        keys[3][1] = 1'b0;
        wait_released("k0", 100);

        // r1+r2 in c0 together: lowest row wins; c2 press ignored until release.
        v0 = valid_cnt;
        keys[1][0] = 1'b1;
        keys[2][0] = 1'b1;
        wait_valid("multi", 100);
        check("multi_code", 32'(key_code), 32'h4);
        keys[0][2] = 1'b1;
        repeat (50) @(negedge clk);
        check("multi_ignore", 32'(valid_cnt - v0), 32'd1);
        check("multi_code_hold", 32'(key_code), 32'h4);
        keys[1][0] = 1'b0;
        keys[2][0] = 1'b0;
        wait_released("multi", 100);
        wait_valid("after", 100);
        check("after_code", 32'(key_code), 32'h3);
        keys[0][2] = 1'b0;
        wait_released("after", 100);

        // Reset while a key is held in PRESSED.
        keys[2][1] = 1'b1;
        wait_valid("rstk", 100);
        check("rstk_code", 32'(key_code), 32'h8);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstk_col", 32'(col_n), 32'hE);
        check("rstk_code_clr", 32'(key_code), 32'h0);
        check("rstk_pressed_clr", 32'(key_pressed), 32'd0);
        repeat (2) @(negedge clk);
        v0 = valid_cnt;
        rst_n = 1'b1;
        wait_valid("rstk_again", 100);
        check("rstk_again_code", 32'(key_code), 32'h8);
        repeat (30) @(negedge clk);
        check("rstk_again_one", 32'(valid_cnt - v0), 32'd1);
        keys[2][1] = 1'b0;
        wait_released("rstk", 100);

        check("valid_width", 32'(wide_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
